spi_data_latch: RTL

SPI_DATA_LATCH -- requirements
Module: spi_data_latch

---
 rtl/spi_data_latch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_data_latch.sv
// ---------------------------------------------------------------------------
// spi_data_latch
//
// Punts a CPU bus cycle (RTC, joystick, POTGOR) to an external MCU over SPI.
// When the decode stage raises a REQ_* line during an address strobe, a
// descriptor byte {RW, REQ_RTC, REQ_JOY, REQ_BTN, 0, A[3:1]} is latched. The
// MCU then clocks one 8-bit mode-0 frame: the descriptor goes out on MISO and
// the reply byte comes in on MOSI. A complete 8-bit frame latches the reply
// onto D_OUT and raises ACK until the CPU drops AS20. A frame of any other
// length is discarded and the MCU may retry.
//
// Ports
//   CLKCPU_A  in   CPU clock, all state on rising edge
//   RESET_N   in   asynchronous active-low reset
//   AS20      in   CPU address strobe, active low
//   RW        in   CPU direction, 1 = read
//   A[2:0]    in   CPU address bits [3:1]
//   REQ_RTC   in   punt request, RTC
//   REQ_JOY   in   punt request, joystick
//   REQ_BTN   in   punt request, POTGOR
//   SPI_CK    in   SPI clock from MCU (asynchronous)
//   SPI_MOSI  in   SPI data from MCU (asynchronous)
//   SPI_NSS   in   SPI slave select from MCU (asynchronous)
//   SPI_MISO  out  SPI data to MCU
//   D_OUT     out  read data for D[31:24]
//   D_OE      out  data bus output enable, active high
//   ACK       out  completion level to the decode stage
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_data_latch (
    input  logic       CLKCPU_A,
    input  logic       RESET_N,
    input  logic       AS20,
    input  logic       RW,
    input  logic [2:0] A,
    input  logic       REQ_RTC,
    input  logic       REQ_JOY,
    input  logic       REQ_BTN,
    input  logic       SPI_CK,
    input  logic       SPI_MOSI,
    input  logic       SPI_NSS,
    output logic       SPI_MISO,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       ACK
);

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   desc;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic [3:0]          bit_cnt;

    logic sck_p0, sck_p1, sck_p2;
    logic nss_p0, nss_p1, nss_p2;
    logic mosi_p0, mosi_p1;

    logic sck_rise, sck_fall, nss_rise, nss_fall;
    logic any_req;

    // ---- stage p0/p1: two-flop synchronizers; p2: edge-detect history ----
    // MOSI needs no third flop: it is sampled at p1, the same age as the
    // SCK level that produces sck_rise.
    always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            nss_p0  <= 1'b1;
            nss_p1  <= 1'b1;
            nss_p2  <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= SPI_CK;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            nss_p0  <= SPI_NSS;
            nss_p1  <= nss_p0;
            nss_p2  <= nss_p1;
            mosi_p0 <= SPI_MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign nss_rise = nss_p1 & ~nss_p2;
    assign nss_fall = ~nss_p1 & nss_p2;
    assign any_req  = REQ_RTC | REQ_JOY | REQ_BTN;

    // ---- control FSM and SPI shift registers ----
    always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            ACK      <= 1'b0;
            SPI_MISO <= 1'b0;
            D_OUT    <= '0;
            bit_cnt  <= 4'd0;
            desc     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else if (state != S_IDLE && AS20) begin
            // CPU ended the bus cycle: drop everything, even mid-frame.
            state    <= S_IDLE;
            ACK      <= 1'b0;
            SPI_MISO <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!AS20 && any_req) begin
                        desc  <= {RW, REQ_RTC, REQ_JOY, REQ_BTN, 1'b0, A};
                        state <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Edge, not level: NSS already low on entry is ignored.
                    if (nss_fall) begin
                        state    <= S_XFER;
                        bit_cnt  <= 4'd0;
                        rx_sr    <= '0;
                        tx_sr    <= desc;
                        SPI_MISO <= desc[DATA_W-1];
                    end
                end

                S_XFER: begin
                    if (nss_rise) begin
                        SPI_MISO <= 1'b0;
                        if (bit_cnt == 4'd8) begin
                            state <= S_DONE;
                            D_OUT <= rx_sr;
                            ACK   <= 1'b1;
                        end else begin
                            // Wrong length: discard and allow a retry frame.
                            state <= S_REQ;
                        end
                    end else begin
                        if (sck_rise) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], mosi_p1};
                            // Saturate at 9 so any overlong frame stays != 8.
                            if (bit_cnt != 4'd9)
                                bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (sck_fall) begin
                            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                            SPI_MISO <= tx_sr[DATA_W-2];
                        end
                    end
                end

                S_DONE: begin
                    ACK <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational so the bus is released in the same cycle AS20 rises.
    assign D_OE = (state == S_DONE) && RW && !AS20;

endmodule
